// File: rtl/mc_alu.sv
// Multi-cycle RV64/RV32 R-type ALU with a valid/ready request port and a valid/ready result port.
// Define MC_ALU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module mc_alu #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            illegal
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable from valid-high until that edge.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [XLEN-1:0]        rd_q;
  logic                   illegal_q;
  logic                   accept;
  logic                   base_legal;
  logic                   md_legal;
  logic                   md_long;
  logic                   busy_last;
  logic [XLEN-1:0]        alu_res;
  logic [XLEN-1:0]        md_result;
  logic [XLEN-1:0]        md_quick;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign rd        = rd_q;
  assign illegal   = illegal_q;
  assign accept    = in_valid && in_ready;
  assign shamt     = rs2[SHW-1:0];
  assign sra_res   = $signed(rs1) >>> shamt;

  always_comb begin
    base_legal = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  end

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (funct7 == F7_ALT) ? (rs1 - rs2) : (rs1 + rs2);
      3'b001:  alu_res = rs1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      3'b100:  alu_res = rs1 ^ rs2;
      3'b101:  alu_res = (funct7 == F7_ALT) ? sra_res : (rs1 >> shamt);
      3'b110:  alu_res = rs1 | rs2;
      default: alu_res = rs1 & rs2;
    endcase
  end

`ifdef MC_ALU_MULDIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier.
  // DIV: acc = partial remainder, opa = divisor magnitude, opb = dividend/quotient.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  cnt;
  logic            is_mul;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;
  logic            div_signed;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] q_next;
  logic [XLEN-1:0] r_next;

  always_comb begin
    md_legal   = (funct7 == F7_MD) && ((funct3 == 3'b000) || funct3[2]);
    div_signed = !funct3[0];
    div_zero   = (rs2 == '0);
    div_ovf    = div_signed && (rs1 == MIN_NEG) && (rs2 == '1);
    md_long    = md_legal && ((funct3 == 3'b000) || (!div_zero && !div_ovf));
    mag1       = (div_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    mag2       = (div_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    md_quick   = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);
    busy_last  = (cnt == '0);
  end

  always_comb begin
    mul_sum   = acc + (opb[0] ? opa : '0);
    div_sh    = {acc, opb[XLEN-1]};
    div_diff  = div_sh - {1'b0, opa};
    div_ok    = !div_diff[XLEN];
    q_next    = {opb[XLEN-2:0], div_ok};
    r_next    = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    md_result = is_mul ? mul_sum :
                is_rem ? (neg_r ? -r_next : r_next) :
                         (neg_q ? -q_next : q_next);
  end

  always_ff @(posedge clk) begin
    if (accept && md_long) begin
      acc    <= '0;
      cnt    <= SHW'(XLEN - 1);
      is_mul <= (funct3 == 3'b000);
      is_rem <= funct3[1];
      neg_q  <= div_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      neg_r  <= div_signed && rs1[XLEN-1];
      opa    <= (funct3 == 3'b000) ? rs1 : mag2;
      opb    <= (funct3 == 3'b000) ? rs2 : mag1;
    end else if (state == BUSY) begin
      cnt <= cnt - SHW'(1);
      if (is_mul) begin
        acc <= mul_sum;
        opa <= opa << 1;
        opb <= opb >> 1;
      end else begin
        acc <= r_next;
        opb <= q_next;
      end
    end
  end
`else
  assign md_legal  = 1'b0;
  assign md_long   = 1'b0;
  assign busy_last = 1'b1;
  assign md_result = '0;
  assign md_quick  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = md_long ? BUSY : DONE;
      BUSY:    if (busy_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rd/illegal are only non-zero while DONE; they are cleared on release or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (base_legal) begin
              rd_q      <= alu_res;
              illegal_q <= 1'b0;
            end else if (md_legal) begin
              rd_q      <= md_long ? '0 : md_quick;
              illegal_q <= 1'b0;
            end else begin
              rd_q      <= '0;
              illegal_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (busy_last) rd_q <= md_result;
        end
        DONE: begin
          if (out_ready) begin
            rd_q      <= '0;
            illegal_q <= 1'b0;
          end
        end
        default: begin
          rd_q      <= '0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter XLEN, default 64, sets operand/result width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), sets the shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  request present on funct3/funct7/rs1/rs2.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 funct3  input  3  RISC-V R-type funct3.
REQ-008 funct7  input  7  RISC-V R-type funct7.
REQ-009 rs1  input  XLEN  first operand.
REQ-010 rs2  input  XLEN  second operand.
REQ-011 out_valid  output  1  rd/illegal hold a completed result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 rd  output  XLEN  result.
REQ-014 illegal  output  1  completed request was an undecodable funct3/funct7 pair.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, and operands are captured at that edge.
REQ-017 Base ops (funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7 0100000: SUB, SRA) SHALL transition IDLE->DONE, asserting out_valid the cycle after acceptance.
REQ-018 Shifts SHALL use rs2[SHW-1:0] only; SRA SHALL sign-fill; SLT is signed, SLTU unsigned, and both return 0 or 1 zero-extended.
REQ-019 ADD/SUB SHALL wrap modulo 2^XLEN; no carry or overflow output.
REQ-020 With funct7 0000001, funct3 000 (MUL) SHALL run a radix-2 shift-add for exactly XLEN BUSY cycles and return the low XLEN bits of the product; out_valid asserts XLEN+1 cycles after acceptance.
REQ-021 funct3 100/101/110/111 (DIV/DIVU/REM/REMU) SHALL run restoring division for exactly XLEN BUSY cycles, operating on magnitudes for signed ops and fixing signs on the BUSY->DONE transition; latency XLEN+1.
REQ-022 Divide by zero SHALL go IDLE->DONE (latency 1): quotient all-ones, remainder rs1.
REQ-023 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL go IDLE->DONE (latency 1): DIV returns rs1, REM returns 0.
REQ-024 Any other funct3/funct7 pair SHALL go IDLE->DONE with rd = 0 and illegal = 1; illegal SHALL be 0 for every decoded op.
REQ-025 In DONE, rd, illegal and out_valid SHALL hold stable until out_ready = 1; on that edge the FSM returns to IDLE and out_valid drops.
REQ-026 in_valid during BUSY/DONE SHALL be ignored (in_ready = 0); no request queuing or overlap.
REQ-027 rd SHALL be 0 in IDLE and BUSY; its value is defined only while out_valid = 1.

Reset
REQ-028 rst_n = 0 at a clock edge SHALL force IDLE with out_valid = 0, rd = 0, illegal = 0 and in_ready = 1 on the following cycle.
REQ-029 Reset during BUSY or DONE SHALL abort the operation and discard its result; no result is ever presented for the aborted request.

Configuration
REQ-030 Macro MC_ALU_MULDIV_EN defined: funct7 0000001 ops behave as in REQ-020..REQ-023.
REQ-031 Macro MC_ALU_MULDIV_EN undefined: no multiply/divide datapath is synthesised, and every funct7 0000001 request completes with latency 1, rd = 0, illegal = 1.

Verification (XLEN = 64)
REQ-032 Reset, then ADD rs1 = 0xFFFF_FFFF_FFFF_FFFF, rs2 = 1, out_ready = 1 -> out_valid one cycle later, rd = 0, illegal = 0; SRA rs1 = 0x8000_0000_0000_0000, rs2 = 0x43 -> rd = 0xF000_0000_0000_0000.
REQ-033 MUL rs1 = 0x1_0000_0001, rs2 = 0x1_0000_0001 -> out_valid exactly 65 cycles after acceptance, rd = 0x2_0000_0001, in_ready = 0 throughout.
REQ-034 DIV rs1 = -7, rs2 = 2 -> rd = -3; REM -> rd = -1; DIVU rs1 = 5, rs2 = 0 -> latency 1, rd = all-ones; DIV rs1 = 0x8000_0000_0000_0000, rs2 = -1 -> rd = 0x8000_0000_0000_0000.
REQ-035 Hold out_ready = 0 for 10 cycles after SLT rs1 = -1, rs2 = 0 -> rd = 1 and out_valid = 1 stable all 10 cycles; in_valid pulses during that window are not accepted.
REQ-036 Assert rst_n = 0 in cycle 20 of a DIVU -> IDLE with out_valid = 0 on the next cycle, no stale result; funct3 = 000, funct7 = 0000010 -> illegal = 1, rd = 0.
